uart_reg_bridge: RTL and testbench

//  Command responder on the far end of the UART byte streams: consumes bytes from uart_rx,

---
 rtl/uart_reg_bridge_pkg.sv | 19 +
 rtl/uart_reg_bridge_if.sv | 27 ++
 rtl/uart_reg_bridge_timer.sv | 27 ++
 rtl/uart_reg_bridge.sv | 134 +++++++++++++
 tb/tb_uart_reg_bridge.sv | 199 +++++++++++++++++++
 5 files changed

// File: rtl/uart_reg_bridge_pkg.sv
// Shared constants and state encoding for the UART-to-register-bus command bridge.
package uart_reg_bridge_pkg;

  localparam logic [7:0] OP_WR   = 8'h57;
  localparam logic [7:0] OP_RD   = 8'h52;
  localparam logic [7:0] RSP_ACK = 8'h41;
  localparam logic [7:0] RSP_ERR = 8'h45;
  localparam logic [7:0] RSP_TMO = 8'h54;
  localparam logic [7:0] RSP_OVR = 8'h4F;

  typedef enum logic [2:0] {
    IDLE,
    GET_ADDR,
    GET_DATA,
    BUS,
    SEND
  } state_t;

endpackage

// File: rtl/uart_reg_bridge_if.sv
// Byte streams from/to the UART plus the register-bus request/ack channel.
interface uart_reg_bridge_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8
) ();
  logic [DATA_WIDTH-1:0] rx_data;
  logic                  rx_valid;
  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_valid;
  logic                  tx_ready;
  logic                  bus_req;
  logic                  bus_we;
  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [DATA_WIDTH-1:0] bus_wdata;
  logic                  bus_ack;
  logic [DATA_WIDTH-1:0] bus_rdata;

  modport master (
    input  rx_data, rx_valid, tx_ready, bus_ack, bus_rdata,
    output tx_data, tx_valid, bus_req, bus_we, bus_addr, bus_wdata
  );

  modport slave (
    output rx_data, rx_valid, tx_ready, bus_ack, bus_rdata,
    input  tx_data, tx_valid, bus_req, bus_we, bus_addr, bus_wdata
  );
endinterface

// File: rtl/uart_reg_bridge_timer.sv
// Loadable down-counter; expired is high once PERIOD enabled cycles have elapsed since load.
module uart_reg_bridge_timer #(
  parameter int unsigned PERIOD = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic en,
  output logic expired
);
  localparam int unsigned W = $clog2(PERIOD + 1);

  logic [W-1:0] cnt;

  // Loading PERIOD-1 makes the zero count coincide with the last waiting cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= W'(PERIOD - 1);
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign expired = (cnt == '0);
endmodule

// File: rtl/uart_reg_bridge.sv
// Decodes W/R commands from the UART byte stream, runs one register-bus access, returns one byte.
module uart_reg_bridge
  import uart_reg_bridge_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned TIMEOUT_CYC = 1_000_000,
  parameter int unsigned BUS_TMO_CYC = 256
) (
  input  logic              clk,
  input  logic              rst,
  uart_reg_bridge_if.master bif
);
  state_t                state, state_n;
  logic                  we_q, we_n;
  logic [ADDR_WIDTH-1:0] addr_q, addr_n;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_n;
  logic [DATA_WIDTH-1:0] resp_q, resp_n;
  logic                  ovr_q, ovr_n;
  logic                  bus_load;
  logic                  ibt_exp;
  logic                  bus_exp;

  uart_reg_bridge_timer #(.PERIOD(TIMEOUT_CYC)) u_ibt (
    .clk     (clk),
    .rst     (rst),
    .load    (bif.rx_valid),
    .en      ((state == GET_ADDR) || (state == GET_DATA)),
    .expired (ibt_exp)
  );

  uart_reg_bridge_timer #(.PERIOD(BUS_TMO_CYC)) u_bus_tmo (
    .clk     (clk),
    .rst     (rst),
    .load    (bus_load),
    .en      (state == BUS),
    .expired (bus_exp)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      resp_q  <= '0;
      ovr_q   <= 1'b0;
    end else begin
      state   <= state_n;
      we_q    <= we_n;
      addr_q  <= addr_n;
      wdata_q <= wdata_n;
      resp_q  <= resp_n;
      ovr_q   <= ovr_n;
    end
  end

  always_comb begin
    state_n  = state;
    we_n     = we_q;
    addr_n   = addr_q;
    wdata_n  = wdata_q;
    resp_n   = resp_q;
    ovr_n    = ovr_q;
    bus_load = 1'b0;

    if (((state == BUS) || (state == SEND)) && bif.rx_valid) ovr_n = 1'b1;

    case (state)
      IDLE: begin
        if (bif.rx_valid) begin
          if (bif.rx_data == OP_WR) begin
            we_n    = 1'b1;
            state_n = GET_ADDR;
          end else if (bif.rx_data == OP_RD) begin
            we_n    = 1'b0;
            state_n = GET_ADDR;
          end else begin
            resp_n  = RSP_ERR;
            state_n = SEND;
          end
        end
      end
      GET_ADDR: begin
        if (bif.rx_valid) begin
          addr_n = bif.rx_data[ADDR_WIDTH-1:0];
          if (we_q) begin
            state_n = GET_DATA;
          end else begin
            state_n  = BUS;
            bus_load = 1'b1;
          end
        end else if (ibt_exp) begin
          state_n = IDLE;
        end
      end
      GET_DATA: begin
        if (bif.rx_valid) begin
          wdata_n  = bif.rx_data;
          state_n  = BUS;
          bus_load = 1'b1;
        end else if (ibt_exp) begin
          state_n = IDLE;
        end
      end
      BUS: begin
        // An overrun byte arriving on the ack cycle itself still poisons this response.
        if (bif.bus_ack) begin
          state_n = SEND;
          if (ovr_n) begin
            resp_n = RSP_OVR;
            ovr_n  = 1'b0;
          end else begin
            resp_n = we_q ? RSP_ACK : bif.bus_rdata;
          end
        end else if (bus_exp) begin
          state_n = SEND;
          resp_n  = RSP_TMO;
        end
      end
      SEND: begin
        if (bif.tx_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bif.bus_req   = (state == BUS);
  assign bif.bus_we    = we_q;
  assign bif.bus_addr  = addr_q;
  assign bif.bus_wdata = wdata_q;
  assign bif.tx_valid  = (state == SEND);
  assign bif.tx_data   = resp_q;
endmodule

// File: tb/tb_uart_reg_bridge.sv
// Directed table-driven bench for uart_reg_bridge plus hand sequences for timeouts, overrun and reset.
module tb_uart_reg_bridge;
  logic clk = 1'b0;
  logic rst = 1'b1;

  uart_reg_bridge_if #(.DATA_WIDTH(8), .ADDR_WIDTH(8)) bif ();

  uart_reg_bridge #(
    .DATA_WIDTH  (8),
    .ADDR_WIDTH  (8),
    .TIMEOUT_CYC (100),
    .BUS_TMO_CYC (256)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bif (bif)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  b0, b1, b2;
    int unsigned nb;
    int unsigned ack_dly;
    logic [7:0]  rdata;
    int unsigned hold;
    logic        exp_req;
    logic        exp_we;
    logic [7:0]  exp_addr;
    logic [7:0]  exp_wdata;
    logic [7:0]  exp_tx;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  int req_cnt  = 0;
  int txv_cnt  = 0;
  logic req_prev = 1'b0;
  logic txv_prev = 1'b0;

  always @(negedge clk) begin
    if (bif.bus_req && !req_prev) req_cnt++;
    if (bif.tx_valid && !txv_prev) txv_cnt++;
    req_prev = bif.bus_req;
    txv_prev = bif.tx_valid;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    bif.rx_data  = b;
    bif.rx_valid = 1'b1;
    tick();
    bif.rx_valid = 1'b0;
    bif.rx_data  = '0;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    bif.tx_ready = (v.hold == 0);
    send_byte(v.b0);
    if (v.nb > 1) send_byte(v.b1);
    if (v.nb > 2) send_byte(v.b2);
    if (v.exp_req) begin
      check({tag, ".req"}, 32'(bif.bus_req), 32'd1);
      check({tag, ".we"}, 32'(bif.bus_we), 32'(v.exp_we));
      check({tag, ".addr"}, 32'(bif.bus_addr), 32'(v.exp_addr));
      if (v.exp_we) check({tag, ".wdata"}, 32'(bif.bus_wdata), 32'(v.exp_wdata));
      for (int i = 0; i < int'(v.ack_dly); i++) begin
        tick();
        check({tag, ".req_hold"}, 32'({bif.bus_req, bif.bus_addr}), 32'({1'b1, v.exp_addr}));
      end
      bif.bus_rdata = v.rdata;
      bif.bus_ack   = 1'b1;
      tick();
      bif.bus_ack   = 1'b0;
      bif.bus_rdata = '0;
    end
    check({tag, ".req_low"}, 32'(bif.bus_req), 32'd0);
    check({tag, ".tx_valid"}, 32'(bif.tx_valid), 32'd1);
    check({tag, ".tx_data"}, 32'(bif.tx_data), 32'(v.exp_tx));
    for (int i = 0; i < int'(v.hold); i++) begin
      tick();
      check({tag, ".tx_hold"}, 32'({bif.tx_valid, bif.tx_data}), 32'({1'b1, v.exp_tx}));
    end
    bif.tx_ready = 1'b1;
    tick();
    check({tag, ".tx_drop"}, 32'(bif.tx_valid), 32'd0);
  endtask

  vec_t vecs[6];
  vec_t v;

  initial begin
    int n;
    int req_snap;
    int txv_snap;

    vecs[0] = '{8'h57, 8'h10, 8'hA5, 3, 3, 8'h00, 0,  1'b1, 1'b1, 8'h10, 8'hA5, 8'h41};
    vecs[1] = '{8'h52, 8'h22, 8'h00, 2, 0, 8'h3C, 10, 1'b1, 1'b0, 8'h22, 8'h00, 8'h3C};
    vecs[2] = '{8'h7F, 8'h00, 8'h00, 1, 0, 8'h00, 0,  1'b0, 1'b0, 8'h00, 8'h00, 8'h45};
    vecs[3] = '{8'h57, 8'hFF, 8'h00, 3, 1, 8'h00, 0,  1'b1, 1'b1, 8'hFF, 8'h00, 8'h41};
    vecs[4] = '{8'h52, 8'h00, 8'h00, 2, 5, 8'hFF, 2,  1'b1, 1'b0, 8'h00, 8'h00, 8'hFF};
    vecs[5] = '{8'h00, 8'h00, 8'h00, 1, 0, 8'h00, 0,  1'b0, 1'b0, 8'h00, 8'h00, 8'h45};

    bif.rx_data   = '0;
    bif.rx_valid  = 1'b0;
    bif.tx_ready  = 1'b1;
    bif.bus_ack   = 1'b0;
    bif.bus_rdata = '0;

    rst = 1'b1;
    repeat (3) tick();
    check("rst.outputs", 32'({bif.bus_req, bif.bus_we, bif.tx_valid}), 32'd0);
    check("rst.buses", 32'({bif.bus_addr, bif.bus_wdata, bif.tx_data}), 32'd0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Bus timeout: read with no ack.
    send_byte(8'h52);
    send_byte(8'h01);
    n = 0;
    while (bif.bus_req && n < 400) begin
      n++;
      tick();
    end
    check("bustmo.req_cycles", 32'(n), 32'd256);
    check("bustmo.tx", 32'({bif.tx_valid, bif.tx_data}), 32'({1'b1, 8'h54}));
    tick();
    check("bustmo.tx_drop", 32'(bif.tx_valid), 32'd0);

    // Inter-byte timeout: partial write abandoned silently.
    req_snap = req_cnt;
    txv_snap = txv_cnt;
    send_byte(8'h57);
    send_byte(8'h10);
    repeat (150) tick();
    check("ibt.no_req", 32'(req_cnt - req_snap), 32'd0);
    check("ibt.no_tx", 32'(txv_cnt - txv_snap), 32'd0);
    v = '{8'h52, 8'h10, 8'h00, 2, 2, 8'h5A, 0, 1'b1, 1'b0, 8'h10, 8'h00, 8'h5A};
    run_vec(v, "ibt_after");

    // Overrun: byte during BUS poisons this response only.
    send_byte(8'h57);
    send_byte(8'h20);
    send_byte(8'h11);
    check("ovr.req", 32'(bif.bus_req), 32'd1);
    send_byte(8'h99);
    check("ovr.req_still", 32'({bif.bus_req, bif.bus_addr, bif.bus_wdata}), 32'({1'b1, 8'h20, 8'h11}));
    bif.bus_ack = 1'b1;
    tick();
    bif.bus_ack = 1'b0;
    check("ovr.tx", 32'({bif.tx_valid, bif.tx_data}), 32'({1'b1, 8'h4F}));
    tick();
    v = '{8'h52, 8'h20, 8'h00, 2, 1, 8'h77, 0, 1'b1, 1'b0, 8'h20, 8'h00, 8'h77};
    run_vec(v, "ovr_after");

    // Reset during a bus access, then a stray ack outside BUS.
    send_byte(8'h52);
    send_byte(8'h30);
    check("rstmid.req", 32'(bif.bus_req), 32'd1);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    check("rstmid.drop", 32'({bif.bus_req, bif.tx_valid}), 32'd0);
    rst = 1'b0;
    tick();
    txv_snap = txv_cnt;
    bif.bus_ack = 1'b1;
    bif.bus_rdata = 8'hEE;
    tick();
    bif.bus_ack = 1'b0;
    tick();
    check("stray_ack.no_tx", 32'({bif.tx_valid, 8'(txv_cnt - txv_snap)}), 32'd0);
    v = '{8'h57, 8'h31, 8'hC3, 3, 0, 8'h00, 1, 1'b1, 1'b1, 8'h31, 8'hC3, 8'h41};
    run_vec(v, "rst_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule
